// File: rtl/wb_init_sequencer.sv
// Wishbone B4 pipelined master that replays a fixed address/data write table after start_i.
// Optional read-back verify of every write is enabled by defining WB_INIT_SEQ_READBACK_EN.
module wb_init_sequencer #(
  parameter int ENTRIES = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter logic [ENTRIES*ADDR_W-1:0] INIT_ADR = '0,
  parameter logic [ENTRIES*DATA_W-1:0] INIT_DAT = '0
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         start_i,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic                         wb_we_o,
  output logic [ADDR_W-1:0]            wb_adr_o,
  output logic [DATA_W-1:0]            wb_dat_o,
  output logic [DATA_W/8-1:0]          wb_sel_o,
  input  logic                         wb_stall_i,
  input  logic                         wb_ack_i,
  input  logic                         wb_err_i,
  input  logic [DATA_W-1:0]            wb_dat_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [1:0]                   err_code_o,
  output logic [$clog2(ENTRIES+1)-1:0] err_index_o
);
  localparam int IW = $clog2(ENTRIES+1);
  localparam int CW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_RB_REQ, S_RB_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t          r_state, w_state_nx;
  logic [IW-1:0]   r_idx, w_idx_nx, r_eidx, w_eidx_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic            r_done, w_done_nx, r_error, w_error_nx;
  logic [1:0]      r_code, w_code_nx, w_fcode;
  logic            w_adv, w_fail, w_last, w_tmo, w_cyc;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_dat;

  assign w_adr  = INIT_ADR[r_idx*ADDR_W +: ADDR_W];
  assign w_dat  = INIT_DAT[r_idx*DATA_W +: DATA_W];
  assign w_last = (r_idx == IW'(ENTRIES-1));
  assign w_tmo  = (r_cnt == CW'(TIMEOUT-1));

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_done_nx  = r_done;
    w_error_nx = r_error;
    w_code_nx  = r_code;
    w_eidx_nx  = r_eidx;
    w_adv      = 1'b0;
    w_fail     = 1'b0;
    w_fcode    = 2'd0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start_i) begin
        w_state_nx = S_REQ;
        w_idx_nx   = '0;
        w_done_nx  = 1'b0;
        w_error_nx = 1'b0;
        w_code_nx  = 2'd0;
        w_eidx_nx  = '0;
      end
      S_REQ: if (!wb_stall_i) begin
        w_state_nx = S_WAIT;
        w_cnt_nx   = '0;
      end
      S_WAIT: begin
        // err outranks a simultaneous ack
        if (wb_err_i) begin
          w_fail = 1'b1; w_fcode = 2'd1;
        end else if (wb_ack_i) begin
`ifdef WB_INIT_SEQ_READBACK_EN
          w_state_nx = S_RB_REQ;
`else
          w_adv = 1'b1;
`endif
        end else if (w_tmo) begin
          w_fail = 1'b1; w_fcode = 2'd2;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
`ifdef WB_INIT_SEQ_READBACK_EN
      S_RB_REQ: if (!wb_stall_i) begin
        w_state_nx = S_RB_WAIT;
        w_cnt_nx   = '0;
      end
      S_RB_WAIT: begin
        if (wb_err_i) begin
          w_fail = 1'b1; w_fcode = 2'd1;
        end else if (wb_ack_i) begin
          if (wb_dat_i == w_dat) w_adv = 1'b1;
          else begin
            w_fail = 1'b1; w_fcode = 2'd3;
          end
        end else if (w_tmo) begin
          w_fail = 1'b1; w_fcode = 2'd2;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
    if (w_adv) begin
      if (w_last) begin
        w_state_nx = S_DONE;
        w_done_nx  = 1'b1;
      end else begin
        w_state_nx = S_REQ;
        w_idx_nx   = r_idx + 1'b1;
      end
    end
    if (w_fail) begin
      w_state_nx = S_ERROR;
      w_error_nx = 1'b1;
      w_code_nx  = w_fcode;
      w_eidx_nx  = r_idx;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_code  <= 2'd0;
      r_eidx  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_done_nx;
      r_error <= w_error_nx;
      r_code  <= w_code_nx;
      r_eidx  <= w_eidx_nx;
    end
  end

`ifdef WB_INIT_SEQ_READBACK_EN
  assign w_cyc    = (r_state == S_REQ) || (r_state == S_WAIT) ||
                    (r_state == S_RB_REQ) || (r_state == S_RB_WAIT);
  assign wb_stb_o = (r_state == S_REQ) || (r_state == S_RB_REQ);
`else
  logic w_unused_dat;
  assign w_unused_dat = ^wb_dat_i;
  assign w_cyc    = (r_state == S_REQ) || (r_state == S_WAIT);
  assign wb_stb_o = (r_state == S_REQ);
`endif

  assign wb_cyc_o    = w_cyc;
  assign busy_o      = w_cyc;
  assign wb_we_o     = (r_state == S_REQ);
  assign wb_adr_o    = w_cyc ? w_adr : '0;
  assign wb_dat_o    = w_cyc ? w_dat : '0;
  assign wb_sel_o    = '1;
  assign done_o      = r_done;
  assign error_o     = r_error;
  assign err_code_o  = r_code;
  assign err_index_o = r_eidx;
endmodule

// File: tb/tb_wb_init_sequencer.sv
// Self-checking bench for wb_init_sequencer: reactive slave model plus transfer scoreboard.
module tb_wb_init_sequencer;
  localparam int ENTRIES = 3;
  localparam int TIMEOUT = 15;
  localparam logic [ENTRIES*32-1:0] ADRS = {32'd2, 32'd1, 32'd0};
  localparam logic [ENTRIES*32-1:0] DATS = {32'hF, 32'hF, 32'hF};
`ifdef WB_INIT_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int P = RB ? 4 : 2;

  typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; } xfer_t;
  xfer_t sb[$];

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic cyc, stb, we, busy, done, error;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0] sel;
  logic [1:0] code, eidx;
  logic s_stall = 1'b0, s_ack = 1'b0, s_err = 1'b0, f_ack = 1'b0;
  logic [31:0] s_dat = '0;
  logic ack;
  assign ack = s_ack | f_ack;
  assign dat_i = s_dat;

  int errors = 0, checks = 0;
  int stall_entry = -1, stall_left = 0, noack_entry = -1, err_entry = -1, flip_entry = -1;
  logic acc = 1'b0, acc_we = 1'b0;
  logic [31:0] acc_adr = '0;
  logic [31:0] e_dat [ENTRIES];
  logic [31:0] e_adr [ENTRIES];

  wb_init_sequencer #(.ENTRIES(ENTRIES), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT),
                      .INIT_ADR(ADRS), .INIT_DAT(DATS)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat_o),
    .wb_sel_o(sel), .wb_stall_i(s_stall), .wb_ack_i(ack), .wb_err_i(s_err),
    .wb_dat_i(dat_i), .busy_o(busy), .done_o(done), .error_o(error),
    .err_code_o(code), .err_index_o(eidx));

  always #5 clk = ~clk;

  // slave: latch accepted request at negedge, respond one cycle later
  always @(negedge clk) begin
    acc     = cyc && stb && !s_stall;
    acc_adr = adr;
    acc_we  = we;
  end

  always @(posedge clk) begin
    #1;
    s_ack = 1'b0; s_err = 1'b0; s_dat = '0; s_stall = 1'b0;
    if (acc && rst_n) begin
      if (int'(acc_adr) == err_entry) begin
        s_err = 1'b1; s_ack = 1'b1;
      end else if (!(acc_we && int'(acc_adr) == noack_entry)) begin
        s_ack = 1'b1;
        if (!acc_we && acc_adr < ENTRIES)
          s_dat = e_dat[int'(acc_adr)] ^ ((int'(acc_adr) == flip_entry) ? 32'd1 : 32'd0);
      end
    end
    if (cyc && stb && we && int'(adr) == stall_entry && stall_left > 0) begin
      s_stall = 1'b1;
      stall_left--;
    end
  end

  // scoreboard: every accepted request must match the next expected transfer
  always @(negedge clk) begin
    if (rst_n && cyc && stb && !s_stall) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: adr=%0h we=%0b, none expected", adr, we);
      end else begin
        xfer_t x;
        x = sb.pop_front();
        if (adr !== x.adr || we !== x.we || (x.we && dat_o !== x.dat)) begin
          errors++;
          $display("FAIL sb_xfer: got adr=%0h we=%0b dat=%0h, want adr=%0h we=%0b dat=%0h",
                   adr, we, dat_o, x.adr, x.we, x.dat);
        end
      end
    end
  end

  task automatic push_w(input int i);
    xfer_t x;
    x.adr = e_adr[i]; x.dat = e_dat[i]; x.we = 1'b1;
    sb.push_back(x);
  endtask

  task automatic push_r(input int i);
    xfer_t x;
    x.adr = e_adr[i]; x.dat = e_dat[i]; x.we = 1'b0;
    sb.push_back(x);
  endtask

  task automatic push_full();
    for (int i = 0; i < ENTRIES; i++) begin
      push_w(i);
      if (RB) push_r(i);
    end
  endtask

  // caller sits at a negedge; returns at the negedge of the first REQ cycle
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n;
    n = 0;
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done/error after %0d cycles", nm, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cyc, stb, we, busy, done, error, code, eidx, adr, dat_o} !== '0 || sel !== 4'hF) begin
      errors++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b busy=%b done=%b err=%b code=%0d idx=%0d adr=%0h dat=%0h sel=%h, want all 0 sel=f",
               cyc, stb, we, busy, done, error, code, eidx, adr, dat_o, sel);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    push_full();
    do_start();
    for (int k = 1; k <= P*ENTRIES + 2; k++) begin
      logic xs, xb, xd, xw;
      xb = (k <= P*ENTRIES);
      xs = xb && ((k-1) % 2 == 0);
      xd = (k > P*ENTRIES);
      xw = xs && ((k-1) % P == 0);
      checks++;
      if (stb !== xs || busy !== xb || cyc !== xb || done !== xd) begin
        errors++;
        $display("FAIL latency_c%0d: stb=%b busy=%b cyc=%b done=%b, want stb=%b busy=%b done=%b",
                 k, stb, busy, cyc, done, xs, xb, xd);
      end
      if (xs) begin
        checks++;
        if (adr !== 32'((k-1)/P) || we !== xw) begin
          errors++;
          $display("FAIL latency_adr_c%0d: adr=%0h we=%b, want adr=%0h we=%b", k, adr, we, (k-1)/P, xw);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL latency_sb: %0d left, want 0", sb.size());
    end
  endtask

  task automatic test_stall();
    int n;
    stall_entry = 1; stall_left = 4;
    push_full();
    do_start();
    n = 0;
    while (!(stb && we && adr == 32'd1) && n < 50) begin
      @(negedge clk); n++;
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (stb !== 1'b1 || we !== 1'b1 || adr !== 32'd1 || dat_o !== 32'hF || s_stall !== (j < 4)) begin
        errors++;
        $display("FAIL stall_hold_%0d: stb=%b we=%b adr=%0h dat=%0h stall=%b, want 1 1 1 f %b",
                 j, stb, we, adr, dat_o, s_stall, j < 4);
      end
      @(negedge clk);
    end
    wait_end("stall");
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL stall_done: done=%b err=%b sb=%0d, want 1 0 0", done, error, sb.size());
    end
    stall_entry = -1;
  endtask

  task automatic test_timeout();
    int n;
    noack_entry = 2;
    push_w(0); if (RB) push_r(0);
    push_w(1); if (RB) push_r(1);
    push_w(2);
    do_start();
    n = 0;
    while (!(stb && we && adr == 32'd2) && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    n = 0;
    while (cyc && n < 40) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n !== TIMEOUT) begin
      errors++; $display("FAIL timeout_wait_cycles: %0d, want %0d", n, TIMEOUT);
    end
    checks++;
    if (error !== 1'b1 || code !== 2'd2 || eidx !== 2'd2 || cyc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: err=%b code=%0d idx=%0d cyc=%b done=%b, want 1 2 2 0 0",
               error, code, eidx, cyc, done);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL timeout_sb: %0d left, want 0", sb.size());
    end
    noack_entry = -1;
  endtask

  task automatic test_bus_error();
    err_entry = 0;
    push_w(0);
    do_start();
    wait_end("buserr");
    checks++;
    if (error !== 1'b1 || code !== 2'd1 || eidx !== 2'd0 || done !== 1'b0 || cyc !== 1'b0) begin
      errors++;
      $display("FAIL buserr_flags: err=%b code=%0d idx=%0d done=%b cyc=%b, want 1 1 0 0 0",
               error, code, eidx, done, cyc);
    end
    err_entry = -1;
    push_full();
    do_start();
    checks++;
    if (error !== 1'b0 || done !== 1'b0 || code !== 2'd0) begin
      errors++;
      $display("FAIL buserr_clear: err=%b done=%b code=%0d, want 0 0 0", error, done, code);
    end
    wait_end("buserr_rerun");
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL buserr_rerun: done=%b err=%b sb=%0d, want 1 0 0", done, error, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    int n;
    noack_entry = 1;
    push_w(0); if (RB) push_r(0);
    push_w(1);
    do_start();
    n = 0;
    while (!(cyc && !stb && adr == 32'd1) && n < 50) begin
      @(negedge clk); n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cyc, stb, we, busy, done, error, code, eidx, adr, dat_o} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: cyc=%b stb=%b we=%b busy=%b done=%b err=%b code=%0d adr=%0h, want all 0",
               cyc, stb, we, busy, done, error, code, adr);
    end
    rst_n = 1'b1;
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (cyc !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late_ack: cyc=%b done=%b err=%b, want 0 0 0", cyc, done, error);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL midrst_sb: %0d left, want 0", sb.size());
    end
    noack_entry = -1;
    push_full();
    do_start();
    checks++;
    if (stb !== 1'b1 || adr !== 32'd0 || we !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: stb=%b adr=%0h we=%b, want 1 0 1", stb, adr, we);
    end
    wait_end("midrst_rerun");
    checks++;
    if (done !== 1'b1 || sb.size() !== 0) begin
      errors++; $display("FAIL midrst_rerun: done=%b sb=%0d, want 1 0", done, sb.size());
    end
  endtask

  task automatic test_readback();
    flip_entry = 1;
    if (RB) begin
      push_w(0); push_r(0); push_w(1); push_r(1);
    end else begin
      push_full();
    end
    do_start();
    wait_end("readback");
    checks++;
    if (RB) begin
      if (error !== 1'b1 || code !== 2'd3 || eidx !== 2'd1 || done !== 1'b0) begin
        errors++;
        $display("FAIL readback_mismatch: err=%b code=%0d idx=%0d done=%b, want 1 3 1 0",
                 error, code, eidx, done);
      end
    end else begin
      if (done !== 1'b1 || error !== 1'b0 || code !== 2'd0) begin
        errors++;
        $display("FAIL readback_off: done=%b err=%b code=%0d, want 1 0 0", done, error, code);
      end
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL readback_sb: %0d left, want 0", sb.size());
    end
    flip_entry = -1;
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      e_adr[i] = ADRS[i*32 +: 32];
      e_dat[i] = DATS[i*32 +: 32];
    end
    test_reset();
    test_latency();
    test_stall();
    test_timeout();
    test_bus_error();
    test_mid_reset();
    test_readback();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
